// File: rtl/vga_timing_gen.sv
// vga_timing_gen: raster counters plus sync/blank timing for the VGA output path.
//
// Parameters: H_/V_ ACTIVE, FP, SYNC, BP timing; H_POL/V_POL asserted sync
// level; PIPE_DELAY (0..15) cycles of delay on o_hsync/o_vsync/o_blank.
// Optional feature macro: VGA_PIX_CE_EN (adds pix_ce; everything advances
// only on pix_ce cycles).
//
// Ports:
//   clk          pixel-domain clock
//   rst          synchronous, active-low reset
//   pix_ce       pixel clock enable (VGA_PIX_CE_EN builds only)
//   curr_x       horizontal position, 0..H_TOTAL-1
//   curr_y       vertical position, 0..V_TOTAL-1
//   active       visible-region flag aligned with curr_x/curr_y
//   line_start   pulse on curr_x==0
//   frame_start  pulse on curr_x==0 and curr_y==0
//   o_hsync      hsync delayed by PIPE_DELAY
//   o_vsync      vsync delayed by PIPE_DELAY
//   o_blank      ~active delayed by PIPE_DELAY (1 = blank)

`default_nettype none

module vga_timing_gen #(
   parameter int unsigned H_ACTIVE   = 640,
   parameter int unsigned H_FP       = 16,
   parameter int unsigned H_SYNC     = 96,
   parameter int unsigned H_BP       = 48,
   parameter int unsigned V_ACTIVE   = 480,
   parameter int unsigned V_FP       = 10,
   parameter int unsigned V_SYNC     = 2,
   parameter int unsigned V_BP       = 33,
   parameter bit          H_POL      = 1'b0,
   parameter bit          V_POL      = 1'b0,
   parameter int unsigned PIPE_DELAY = 3
) (
   input  logic        clk,
   input  logic        rst,
`ifdef VGA_PIX_CE_EN
   input  logic        pix_ce,
`endif
   output logic [10:0] curr_x,
   output logic [9:0]  curr_y,
   output logic        active,
   output logic        line_start,
   output logic        frame_start,
   output logic        o_hsync,
   output logic        o_vsync,
   output logic        o_blank
);

   localparam int unsigned X_W      = 11;
   localparam int unsigned Y_W      = 10;
   localparam int unsigned H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int unsigned V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
   localparam int unsigned HS_START = H_ACTIVE + H_FP;
   localparam int unsigned HS_END   = HS_START + H_SYNC;
   localparam int unsigned VS_START = V_ACTIVE + V_FP;
   localparam int unsigned VS_END   = VS_START + V_SYNC;

   // Reject timings that do not fit the counter widths.
   if (H_TOTAL > 2048) begin : g_bad_h_total
      $error("vga_timing_gen: H_TOTAL %0d exceeds 2048", H_TOTAL);
   end
   if (V_TOTAL > 1024) begin : g_bad_v_total
      $error("vga_timing_gen: V_TOTAL %0d exceeds 1024", V_TOTAL);
   end
   if (PIPE_DELAY > 15) begin : g_bad_delay
      $error("vga_timing_gen: PIPE_DELAY %0d out of range 0..15", PIPE_DELAY);
   end

   logic           adv_c;
   logic [X_W-1:0] curr_x_q, curr_x_d;
   logic [Y_W-1:0] curr_y_q, curr_y_d;
   logic           x_last_c, y_last_c;
   logic           hs_raw_c, vs_raw_c;
   logic [2:0]     raw_c;

`ifdef VGA_PIX_CE_EN
   assign adv_c = pix_ce;
`else
   assign adv_c = 1'b1;
`endif

   assign x_last_c = (curr_x_q == X_W'(H_TOTAL - 1));
   assign y_last_c = (curr_y_q == Y_W'(V_TOTAL - 1));

   // Raster counter next state: x wraps each line, y steps on the x wrap.
   always_comb begin
      curr_x_d = curr_x_q;
      curr_y_d = curr_y_q;
      if (adv_c) begin
         if (x_last_c) begin
            curr_x_d = '0;
            curr_y_d = y_last_c ? '0 : curr_y_q + Y_W'(1);
         end else begin
            curr_x_d = curr_x_q + X_W'(1);
         end
      end
   end

   // Counter registers; reset drops the position immediately.
   always_ff @(posedge clk) begin
      if (!rst) begin
         curr_x_q <= '0;
         curr_y_q <= '0;
      end else begin
         curr_x_q <= curr_x_d;
         curr_y_q <= curr_y_d;
      end
   end

   assign curr_x = curr_x_q;
   assign curr_y = curr_y_q;

   // Decodes compare at 32 bits so a window end equal to the counter range cannot alias.
   assign active   = (32'(curr_x_q) < H_ACTIVE) && (32'(curr_y_q) < V_ACTIVE);
   assign hs_raw_c = ((32'(curr_x_q) >= HS_START) && (32'(curr_x_q) < HS_END)) ? H_POL : ~H_POL;
   assign vs_raw_c = ((32'(curr_y_q) >= VS_START) && (32'(curr_y_q) < VS_END)) ? V_POL : ~V_POL;
   assign raw_c    = {hs_raw_c, vs_raw_c, ~active};

   assign line_start  = (curr_x_q == '0) & rst & adv_c;
   assign frame_start = line_start & (curr_y_q == '0);

   // Sync/blank delay line keeps pin timing aligned with the pixel pipeline.
   if (PIPE_DELAY == 0) begin : g_no_delay
      assign {o_hsync, o_vsync, o_blank} = raw_c;
   end else begin : g_delay
      logic [2:0] pipe_q [PIPE_DELAY];

      always_ff @(posedge clk) begin
         if (!rst) begin
            for (int unsigned i = 0; i < PIPE_DELAY; i++) begin
               pipe_q[i] <= {~H_POL, ~V_POL, 1'b1};
            end
         end else if (adv_c) begin
            pipe_q[0] <= raw_c;
            for (int unsigned i = 1; i < PIPE_DELAY; i++) begin
               pipe_q[i] <= pipe_q[i-1];
            end
         end
      end

      assign {o_hsync, o_vsync, o_blank} = pipe_q[PIPE_DELAY-1];
   end

endmodule

`default_nettype wire

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen: self-checking bench for vga_timing_gen.
// Instance 0 uses default 640x480 timing; instance 1 uses a tiny raster with
// active-high syncs and PIPE_DELAY=2 so whole frames fit in a short run.
// A model tracks the raster; expected sync/blank words are queued per advancing
// edge and popped as they reach the delayed outputs.

module tb_vga_timing_gen;

   localparam int HA [2] = '{640, 16};
   localparam int HF [2] = '{16, 2};
   localparam int HS [2] = '{96, 4};
   localparam int HB [2] = '{48, 3};
   localparam int VA [2] = '{480, 8};
   localparam int VF [2] = '{10, 2};
   localparam int VS [2] = '{2, 2};
   localparam int VB [2] = '{33, 3};
   localparam bit HP [2] = '{1'b0, 1'b1};
   localparam bit VP [2] = '{1'b0, 1'b1};
   localparam int PD [2] = '{3, 2};

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic [10:0] x0, x1;
   logic [9:0]  y0, y1;
   logic        act0, act1, ls0, ls1, fs0, fs1;
   logic        hs0, hs1, vs0, vs1, bl0, bl1;

   int n_chk = 0;
   int n_bad = 0;

   int mx [2];
   int my [2];
   logic [2:0] q0 [$];
   logic [2:0] q1 [$];

   int hs_lo_cnt = 0;
   bit hs_ok     = 1'b0;
   int bl_lo_cnt = 0;
   int vs_on_cnt = 0;
   bit fr_ok     = 1'b0;

   always #5 clk = ~clk;

   vga_timing_gen u_dut (
      .clk        (clk),
      .rst        (rst),
`ifdef VGA_PIX_CE_EN
      .pix_ce     (1'b1),
`endif
      .curr_x     (x0),
      .curr_y     (y0),
      .active     (act0),
      .line_start (ls0),
      .frame_start(fs0),
      .o_hsync    (hs0),
      .o_vsync    (vs0),
      .o_blank    (bl0)
   );

   vga_timing_gen #(
      .H_ACTIVE(16), .H_FP(2), .H_SYNC(4), .H_BP(3),
      .V_ACTIVE(8),  .V_FP(2), .V_SYNC(2), .V_BP(3),
      .H_POL(1'b1),  .V_POL(1'b1), .PIPE_DELAY(2)
   ) u_dut_s (
      .clk        (clk),
      .rst        (rst),
`ifdef VGA_PIX_CE_EN
      .pix_ce     (1'b1),
`endif
      .curr_x     (x1),
      .curr_y     (y1),
      .active     (act1),
      .line_start (ls1),
      .frame_start(fs1),
      .o_hsync    (hs1),
      .o_vsync    (vs1),
      .o_blank    (bl1)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s got=%0d exp=%0d t=%0t", tag, got, exp, $time);
      end
   endtask

   // Expected {hsync, vsync, blank} for raster position (x, y) of instance i.
   function automatic logic [2:0] dec(input int i, input int x, input int y);
      logic h, v, b;
      h = (x >= HA[i] + HF[i] && x < HA[i] + HF[i] + HS[i]) ? HP[i] : ~HP[i];
      v = (y >= VA[i] + VF[i] && y < VA[i] + VF[i] + VS[i]) ? VP[i] : ~VP[i];
      b = !(x < HA[i] && y < VA[i]);
      return {h, v, b};
   endfunction

   // Advance the model by one clock edge.
   task automatic model_edge(input int i);
      logic [2:0] d;
      logic [2:0] rv;
      if (!rst) begin
         mx[i] = 0;
         my[i] = 0;
         rv    = {~HP[i], ~VP[i], 1'b1};
         if (i == 0) begin
            q0.delete();
            for (int k = 0; k < PD[0]; k++) q0.push_back(rv);
         end else begin
            q1.delete();
            for (int k = 0; k < PD[1]; k++) q1.push_back(rv);
         end
      end else begin
         d = dec(i, mx[i], my[i]);
         if (i == 0) begin
            void'(q0.pop_front());
            q0.push_back(d);
         end else begin
            void'(q1.pop_front());
            q1.push_back(d);
         end
         if (mx[i] == HA[i] + HF[i] + HS[i] + HB[i] - 1) begin
            mx[i] = 0;
            my[i] = (my[i] == VA[i] + VF[i] + VS[i] + VB[i] - 1) ? 0 : my[i] + 1;
         end else begin
            mx[i] = mx[i] + 1;
         end
      end
   endtask

   task automatic check_inst(input int i, input logic [10:0] x, input logic [9:0] y,
                             input logic act, input logic ls, input logic fs,
                             input logic hs, input logic vs, input logic bl);
      logic [2:0] e;
      logic       els;
      e   = (i == 0) ? q0[0] : q1[0];
      els = (mx[i] == 0) && rst;
      chk($sformatf("d%0d_x", i), 32'(x), mx[i]);
      chk($sformatf("d%0d_y", i), 32'(y), my[i]);
      chk($sformatf("d%0d_active", i), 32'(act), 32'(mx[i] < HA[i] && my[i] < VA[i]));
      chk($sformatf("d%0d_line_start", i), 32'(ls), 32'(els));
      chk($sformatf("d%0d_frame_start", i), 32'(fs), 32'(els && my[i] == 0));
      chk($sformatf("d%0d_hsync", i), 32'(hs), 32'(e[2]));
      chk($sformatf("d%0d_vsync", i), 32'(vs), 32'(e[1]));
      chk($sformatf("d%0d_blank", i), 32'(bl), 32'(e[0]));
   endtask

   // Per-line hsync width on instance 0, per-frame blank/vsync totals on instance 1.
   task automatic window_counts();
      if (!rst) begin
         hs_ok = 1'b0;
         fr_ok = 1'b0;
      end else begin
         if (mx[0] == 0) begin
            if (hs_ok) chk("hsync_width", hs_lo_cnt, 96);
            hs_lo_cnt = 0;
            hs_ok     = 1'b1;
         end
         if (hs0 == 1'b0) hs_lo_cnt++;
         if (mx[1] == 0 && my[1] == 0) begin
            if (fr_ok) begin
               chk("blank_low_per_frame", bl_lo_cnt, 16 * 8);
               chk("vsync_on_per_frame", vs_on_cnt, 2 * 25);
            end
            bl_lo_cnt = 0;
            vs_on_cnt = 0;
            fr_ok     = 1'b1;
         end
         if (bl1 == 1'b0) bl_lo_cnt++;
         if (vs1 == 1'b1) vs_on_cnt++;
      end
   endtask

   task automatic run(input int n);
      repeat (n) begin
         @(posedge clk);
         model_edge(0);
         model_edge(1);
         #1;
         check_inst(0, x0, y0, act0, ls0, fs0, hs0, vs0, bl0);
         check_inst(1, x1, y1, act1, ls1, fs1, hs1, vs1, bl1);
         window_counts();
      end
   endtask

   initial begin
      rst = 1'b0;
      run(6);
      rst = 1'b1;
      run(800 * 12 + 100);
      // Mid-frame reset, then restart from the origin.
      rst = 1'b0;
      run(5);
      rst = 1'b1;
      run(2000);
      $display("test done: total=%0d bad=%0d", n_chk, n_bad);
      $finish;
   end

endmodule

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
- Generates raster scan coordinates and sync/blank timing for the VGA output path.
- Drives the curr_x/curr_y inputs of the downstream image ROM reader and other pixel sources.
- Outputs sync and blank through a configurable delay line. This keeps them aligned with pixel data that arrives PIPE_DELAY cycles after the coordinates.
- Sits directly upstream of the pixel pipeline and the board's VGA pins.

Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch (pixels)
- H_SYNC, 96, horizontal sync width (pixels)
- H_BP, 48, horizontal back porch (pixels)
- V_ACTIVE, 480, visible lines per frame
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vertical sync width (lines)
- V_BP, 33, vertical back porch (lines)
- H_POL, 0, hsync asserted level (0 = active-low)
- V_POL, 0, vsync asserted level (0 = active-low)
- PIPE_DELAY, 3, cycles of delay on o_hsync/o_vsync/o_blank; range 0..15

Ports:
- clk  in  1  pixel-domain clock
- rst  in  1  synchronous, active-low reset
- pix_ce  in  1  pixel clock enable; present only with VGA_PIX_CE_EN
- curr_x  out  11  horizontal counter, 0..H_TOTAL-1
- curr_y  out  10  vertical counter, 0..V_TOTAL-1
- active  out  1  undelayed visible-region flag, aligned with curr_x/curr_y
- line_start  out  1  one-cycle pulse when curr_x==0
- frame_start  out  1  one-cycle pulse when curr_x==0 and curr_y==0
- o_hsync  out  1  hsync delayed by PIPE_DELAY, to pin
- o_vsync  out  1  vsync delayed by PIPE_DELAY, to pin
- o_blank  out  1  ~active delayed by PIPE_DELAY; 1 = blank

Behaviour:
- Totals: H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (default 800); V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP (default 525).
- Elaboration: fail with $error if H_TOTAL > 2048 or V_TOTAL > 1024.
- Reset (rst==0 at a clk edge):
  - curr_x=0, curr_y=0.
  - All delay-line stages load sync-deasserted values (o_hsync=~H_POL, o_vsync=~V_POL) and blank=1.
  - Outputs hold these values for the whole reset.
  - Reset mid-frame discards the position immediately; no completion of the line.
- Counting (rst==1, advance enabled):
  - curr_x increments by 1 each cycle.
  - At curr_x==H_TOTAL-1, curr_x wraps to 0 and curr_y increments in the same cycle.
  - At curr_x==H_TOTAL-1 and curr_y==V_TOTAL-1, both wrap to 0.
  - curr_x and curr_y are flops; no combinational path from inputs.
- Decodes (combinational from the counter flops):
  - active = (curr_x < H_ACTIVE) & (curr_y < V_ACTIVE)
  - hs_raw asserted (=H_POL) when H_ACTIVE+H_FP <= curr_x < H_ACTIVE+H_FP+H_SYNC
  - vs_raw asserted (=V_POL) when V_ACTIVE+V_FP <= curr_y < V_ACTIVE+V_FP+V_SYNC
  - vsync changes only on the line wrap, together with curr_y.
- Pulses:
  - line_start = (curr_x==0) & rst.
  - frame_start = line_start & (curr_y==0).
  - Both are 0 during reset.
  - The first cycle after reset release pulses both.
- Delay line:
  - PIPE_DELAY-stage shift register carrying {hs_raw, vs_raw, ~active}.
  - o_* equals the decode value PIPE_DELAY advancing cycles earlier.
  - PIPE_DELAY=0: o_* are the combinational decodes directly.
- Default alignment: curr_x=656 at cycle t gives o_hsync=0 at cycle t+3.

Optional Feature:
- Macro: VGA_PIX_CE_EN.
- Defined:
  - pix_ce port exists.
  - Counters and delay line advance only on cycles with pix_ce==1; otherwise all hold.
  - line_start and frame_start are additionally ANDed with pix_ce.
  - Reset is not gated by pix_ce.
  - Use case: a 100 MHz clk with a 25 MHz pix_ce strobe.
- Not defined: no pix_ce port; behaviour is as if pix_ce==1 every cycle.

Test Plan:
1. Reset: hold rst=0 for 5 cycles mid-frame → curr_x=0, curr_y=0, o_hsync=1, o_vsync=1, o_blank=1, frame_start=0. On release, frame_start=1 for exactly 1 cycle.
2. Line wrap: run to curr_x=799, curr_y=10 → next cycle curr_x=0, curr_y=11, line_start=1, frame_start=0.
3. Hsync window with delay: hs_raw low exactly for curr_x 656..751 (96 cycles). o_hsync falls 3 cycles after curr_x=656 and rises 3 cycles after curr_x=752.
4. Frame wrap: at (799,524) → next cycle (0,0), frame_start=1. Over a full frame, o_vsync is low for exactly 2×800 cycles, starting 3 cycles after (0,490). Period is 420000 cycles.
5. Blank: o_blank=0 for exactly 640×480 cycles per frame. It deasserts 3 cycles after (0,0); active falls at curr_x=640.
6. VGA_PIX_CE_EN with pix_ce 1-in-4:
   - Counters step once per 4 clk; line period is 3200 clk.
   - Line_start pulses last 1 clk.
   - o_hsync lags by 3 enabled cycles (12 clk).
